axi_grid_sni_wr: RTL and testbench

- Slave-side grid network interface, write path.
- Accepts AXI write requests (AW/W) from a local master and packetises them into grid flits: one header flit, then data flits.
- Takes the returning grid write-response packet and presents it as an AXI B response.
- Counterpart of the master network interface: this block injects what axi_grid_mni consumes. One outstanding transaction at a time.

---
 rtl/axi_grid_sni_wr.sv | 170 +++++++++++++++++
 tb/tb_axi_grid_sni_wr.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_grid_sni_wr.sv
// axi_grid_sni_wr: slave-side grid network interface, write path.
// Turns one AXI write (AW + W burst) into a grid packet: a header flit followed
// by the data flits. The returning grid response is presented as an AXI B.
// Only one transaction is outstanding at a time.
module axi_grid_sni_wr #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int GRID_ID_W = 8,
  parameter int NI_ID     = 0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  // AXI write address
  input  logic [ID_W-1:0]   aw_id_i,
  input  logic [ADDR_W-1:0] aw_addr_i,
  input  logic [7:0]        aw_len_i,
  input  logic              aw_valid_i,
  output logic              aw_ready_o,
  // AXI write data
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              w_last_i,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  // AXI write response
  output logic [ID_W-1:0]   b_id_o,
  output logic [1:0]        b_resp_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  // grid flit injection
  output logic [DATA_W-1:0] tx_flit_o,
  output logic              tx_head_o,
  output logic              tx_tail_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  // grid write response
  input  logic [ID_W-1:0]   rx_id_i,
  input  logic [1:0]        rx_resp_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o
);

  // Header payload: {dst, src, id, len, addr}, LSB-aligned in the flit.
  localparam int HDR_W = 2*GRID_ID_W + ID_W + 8 + ADDR_W;
  localparam logic [GRID_ID_W-1:0] SRC_ID = GRID_ID_W'(NI_ID);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  generate
    if (DATA_W < HDR_W) begin : g_hdr_chk
      $error("axi_grid_sni_wr: DATA_W too narrow for the header flit");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HEAD = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    BOUT = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic [1:0]        resp_q;

  logic              last_beat;
  logic [DATA_W-1:0] hdr_flit;
  logic [GRID_ID_W-1:0] dst_id;

  assign last_beat = (cnt_q == len_q);
  // Destination node is carried in the top address bits.
  assign dst_id    = addr_q[ADDR_W-1 -: GRID_ID_W];

  // Zero-extended header flit built from the captured AW fields.
  always_comb begin
    hdr_flit            = '0;
    hdr_flit[HDR_W-1:0] = {dst_id, SRC_ID, id_q, len_q, addr_q};
  end

  // Next-state and output decode; outputs depend on state and captured
  // registers only, except the W->tx pass-through while in DATA.
  always_comb begin
    state_d    = state_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    tx_valid_o = 1'b0;
    tx_head_o  = 1'b0;
    tx_tail_o  = 1'b0;
    tx_flit_o  = '0;
    rx_ready_o = 1'b0;
    b_valid_o  = 1'b0;
    b_id_o     = '0;
    b_resp_o   = '0;
    case (state_q)
      IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) state_d = HEAD;
      end
      HEAD: begin
        tx_valid_o = 1'b1;
        tx_head_o  = 1'b1;
        tx_flit_o  = hdr_flit;
        if (tx_ready_i) state_d = DATA;
      end
      DATA: begin
        tx_valid_o = w_valid_i;
        w_ready_o  = tx_ready_i;
        tx_flit_o  = w_data_i;
        // Tail comes from the beat count so a bad w_last cannot cut a packet.
        tx_tail_o  = last_beat;
        if (w_valid_i && tx_ready_i && last_beat) state_d = RESP;
      end
      RESP: begin
        rx_ready_o = 1'b1;
        if (rx_valid_i) state_d = BOUT;
      end
      BOUT: begin
        b_valid_o = 1'b1;
        b_id_o    = id_q;
        b_resp_o  = resp_q;
        if (b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Captured request, beat counter, sticky error and response register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      resp_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (aw_valid_i) begin
          id_q   <= aw_id_i;
          addr_q <= aw_addr_i;
          len_q  <= aw_len_i;
          err_q  <= 1'b0;
        end
        HEAD: if (tx_ready_i) cnt_q <= '0;
        DATA: if (w_valid_i && tx_ready_i) begin
          // Any disagreement between w_last and the beat count is sticky.
          if (w_last_i != last_beat) err_q <= 1'b1;
          // Counter holds at len on the final beat, so len=255 never wraps.
          if (!last_beat) cnt_q <= cnt_q + 8'd1;
        end
        RESP: if (rx_valid_i) begin
          resp_q <= (err_q || (rx_id_i != id_q)) ? RESP_SLVERR : rx_resp_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_grid_sni_wr.sv
// Randomised bench for axi_grid_sni_wr: transactions are driven cycle by cycle
// and the observed flits / B response are compared with a packet-level model.
module tb_axi_grid_sni_wr;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int GID_W  = 8;
  localparam logic [7:0] NI = 8'h21;

  logic              clk_i = 1'b0;
  logic              arst_i = 1'b1;
  logic [ID_W-1:0]   aw_id_i = '0;
  logic [ADDR_W-1:0] aw_addr_i = '0;
  logic [7:0]        aw_len_i = '0;
  logic              aw_valid_i = 1'b0;
  logic              aw_ready_o;
  logic [DATA_W-1:0] w_data_i = '0;
  logic              w_last_i = 1'b0;
  logic              w_valid_i = 1'b0;
  logic              w_ready_o;
  logic [ID_W-1:0]   b_id_o;
  logic [1:0]        b_resp_o;
  logic              b_valid_o;
  logic              b_ready_i = 1'b0;
  logic [DATA_W-1:0] tx_flit_o;
  logic              tx_head_o, tx_tail_o, tx_valid_o;
  logic              tx_ready_i = 1'b0;
  logic [ID_W-1:0]   rx_id_i = '0;
  logic [1:0]        rx_resp_i = '0;
  logic              rx_valid_i = 1'b0;
  logic              rx_ready_o;

  axi_grid_sni_wr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                    .GRID_ID_W(GID_W), .NI_ID(int'(NI))) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_last_i(w_last_i), .w_valid_i(w_valid_i),
    .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o),
    .b_ready_i(b_ready_i),
    .tx_flit_o(tx_flit_o), .tx_head_o(tx_head_o), .tx_tail_o(tx_tail_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_id_i(rx_id_i), .rx_resp_i(rx_resp_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Stimulus and observations shared by the driver and the tests.
  logic [DATA_W-1:0] wdata[$];
  logic [DATA_W-1:0] obs_flit[$];
  logic              obs_head[$], obs_tail[$];
  logic [DATA_W-1:0] exp_flit[$];
  logic              exp_head[$], exp_tail[$];
  int cyc_hdr, cyc_dat, cyc_rx, cyc_b;

  // Reference packet: header then every W beat, tail on beat len.
  function automatic void build_exp(input logic [ID_W-1:0] id,
                                    input logic [ADDR_W-1:0] addr,
                                    input logic [7:0] len);
    logic [DATA_W-1:0] h;
    h = '0;
    h[59:0] = {addr[31:24], NI, id, len, addr};
    exp_flit = {}; exp_head = {}; exp_tail = {};
    exp_flit.push_back(h); exp_head.push_back(1'b1); exp_tail.push_back(1'b0);
    for (int i = 0; i <= int'(len); i++) begin
      exp_flit.push_back(wdata[i]);
      exp_head.push_back(1'b0);
      exp_tail.push_back(i == int'(len));
    end
  endfunction

  function automatic logic [1:0] exp_resp(input int last_at, input int len,
                                          input logic [ID_W-1:0] id,
                                          input logic [ID_W-1:0] rid,
                                          input logic [1:0] rresp);
    return (last_at != len || rid != id) ? 2'b10 : rresp;
  endfunction

  function automatic void gen_data(input int n);
    wdata = {};
    for (int i = 0; i < n; i++) wdata.push_back({$urandom, $urandom});
  endfunction

  // Cycle-level driver: one iteration per clock, inputs set #1 after the edge,
  // handshakes decided #2 after the edge. abort>0 stops after that many data
  // flits have been handed over. Cycle stamps are relative to the AW handshake.
  task automatic drive_txn(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len, input int last_at,
                           input logic [ID_W-1:0] rid, input logic [1:0] rresp,
                           input int stall, input int abort,
                           output logic [ID_W-1:0] bid, output logic [1:0] bresp,
                           output bit timed_out);
    bit aw_done = 0, rx_done = 0, done = 0;
    int wi = 0, ndat = 0, aw_cyc = -1;
    obs_flit = {}; obs_head = {}; obs_tail = {};
    cyc_hdr = -1; cyc_dat = -1; cyc_rx = -1; cyc_b = -1;
    bid = '0; bresp = '0; timed_out = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk_i); #1;
      aw_valid_i = !aw_done; aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
      w_valid_i  = (wi <= int'(len)) && ($urandom_range(99) >= stall);
      w_data_i   = (wi <= int'(len)) ? wdata[wi] : '0;
      w_last_i   = (wi == last_at);
      tx_ready_i = $urandom_range(99) >= stall;
      rx_valid_i = !rx_done && ($urandom_range(99) >= stall);
      rx_id_i = rid; rx_resp_i = rresp;
      b_ready_i  = $urandom_range(99) >= stall;
      #1;
      if (aw_valid_i && aw_ready_o) begin aw_done = 1; aw_cyc = c; end
      if (tx_valid_o && tx_head_o && cyc_hdr < 0) cyc_hdr = c - aw_cyc;
      if (tx_valid_o && !tx_head_o && cyc_dat < 0) cyc_dat = c - aw_cyc;
      if (b_valid_o && cyc_b < 0) cyc_b = c - aw_cyc;
      if (tx_valid_o && tx_ready_i) begin
        obs_flit.push_back(tx_flit_o); obs_head.push_back(tx_head_o);
        obs_tail.push_back(tx_tail_o);
        if (!tx_head_o) ndat++;
      end
      if (w_valid_i && w_ready_o) wi++;
      if (rx_valid_i && rx_ready_o) begin rx_done = 1; cyc_rx = c - aw_cyc; end
      if (b_valid_o && b_ready_i) begin bid = b_id_o; bresp = b_resp_o; done = 1; end
      if (done || (abort > 0 && ndat == abort)) begin timed_out = 0; break; end
    end
    @(posedge clk_i); #1;
    aw_valid_i = 0; w_valid_i = 0; w_last_i = 0; tx_ready_i = 0;
    rx_valid_i = 0; b_ready_i = 0;
  endtask

  task automatic test_reset;
    arst_i = 1;
    repeat (3) @(posedge clk_i);
    #1 arst_i = 0;
    @(posedge clk_i); #2;
    total++;
    if ({aw_ready_o, tx_valid_o, w_ready_o, rx_ready_o, b_valid_o} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=10000",
               {aw_ready_o, tx_valid_o, w_ready_o, rx_ready_o, b_valid_o});
    end
    total++;
    if (b_resp_o !== 2'b00 || b_id_o !== '0 || tx_flit_o !== '0) begin
      bad++;
      $display("FAIL reset_data b_resp=%0d b_id=%0d flit=%h want zeros",
               b_resp_o, b_id_o, tx_flit_o);
    end
  endtask

  task automatic test_single;
    logic [ID_W-1:0] bid; logic [1:0] bresp; bit to;
    wdata = {}; wdata.push_back(64'h0000_0000_DEAD_BEEF);
    build_exp(4'd3, 32'h5A00_1000, 8'd0);
    drive_txn(4'd3, 32'h5A00_1000, 8'd0, 0, 4'd3, 2'b00, 0, 0, bid, bresp, to);
    total++;
    if (to) begin bad++; $display("FAIL single_timeout got=1 want=0"); end
    total++;
    if ({cyc_hdr, cyc_dat, cyc_rx, cyc_b} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
      bad++;
      $display("FAIL single_latency got hdr=%0d dat=%0d rx=%0d b=%0d want 1 2 3 4",
               cyc_hdr, cyc_dat, cyc_rx, cyc_b);
    end
    total++;
    if (obs_flit.size() != exp_flit.size()) begin
      bad++;
      $display("FAIL single_count got=%0d want=%0d", obs_flit.size(), exp_flit.size());
    end else begin
      for (int i = 0; i < exp_flit.size(); i++) begin
        total++;
        if ({obs_flit[i], obs_head[i], obs_tail[i]} !== {exp_flit[i], exp_head[i], exp_tail[i]}) begin
          bad++;
          $display("FAIL single_flit%0d got=%h h%0b t%0b want=%h h%0b t%0b", i,
                   obs_flit[i], obs_head[i], obs_tail[i], exp_flit[i], exp_head[i], exp_tail[i]);
        end
      end
    end
    total++;
    if (bid !== 4'd3 || bresp !== 2'b00) begin
      bad++;
      $display("FAIL single_b got id=%0d resp=%0d want id=3 resp=0", bid, bresp);
    end
  endtask

  // Common body for randomised bursts: compares flits and B against the model.
  task automatic test_burst(input string name, input logic [ID_W-1:0] id,
                            input logic [7:0] len, input int last_at,
                            input logic [ID_W-1:0] rid, input logic [1:0] rresp,
                            input int stall);
    logic [ID_W-1:0] bid; logic [1:0] bresp; bit to;
    logic [ADDR_W-1:0] addr;
    logic [1:0] want;
    addr = $urandom;
    gen_data(int'(len) + 1);
    build_exp(id, addr, len);
    want = exp_resp(last_at, int'(len), id, rid, rresp);
    drive_txn(id, addr, len, last_at, rid, rresp, stall, 0, bid, bresp, to);
    total++;
    if (to) begin bad++; $display("FAIL %s_timeout got=1 want=0", name); end
    total++;
    if (obs_flit.size() != exp_flit.size()) begin
      bad++;
      $display("FAIL %s_count got=%0d want=%0d", name, obs_flit.size(), exp_flit.size());
    end else begin
      for (int i = 0; i < exp_flit.size(); i++) begin
        total++;
        if ({obs_flit[i], obs_head[i], obs_tail[i]} !== {exp_flit[i], exp_head[i], exp_tail[i]}) begin
          bad++;
          $display("FAIL %s_flit%0d got=%h h%0b t%0b want=%h h%0b t%0b", name, i,
                   obs_flit[i], obs_head[i], obs_tail[i], exp_flit[i], exp_head[i], exp_tail[i]);
        end
      end
    end
    total++;
    if (bid !== id || bresp !== want) begin
      bad++;
      $display("FAIL %s_b got id=%0d resp=%0d want id=%0d resp=%0d",
               name, bid, bresp, id, want);
    end
  endtask

  task automatic test_reset_mid;
    logic [ID_W-1:0] bid; logic [1:0] bresp; bit to;
    gen_data(6);
    drive_txn(4'd9, 32'h1234_5678, 8'd5, 5, 4'd9, 2'b00, 0, 2, bid, bresp, to);
    total++;
    if (to || !w_ready_o && tx_head_o) begin
      bad++; $display("FAIL midrst_setup got timeout=%0b want=0", to);
    end
    #1 arst_i = 1;
    #1;
    total++;
    if ({aw_ready_o, tx_valid_o, w_ready_o, rx_ready_o, b_valid_o} !== 5'b10000 ||
        tx_flit_o !== '0 || b_resp_o !== 2'b00 || b_id_o !== '0) begin
      bad++;
      $display("FAIL midrst_outputs got ctrl=%b flit=%h b=%0d/%0d want ctrl=10000 zeros",
               {aw_ready_o, tx_valid_o, w_ready_o, rx_ready_o, b_valid_o},
               tx_flit_o, b_id_o, b_resp_o);
    end
    @(posedge clk_i); #1 arst_i = 0;
    test_burst("after_rst", 4'd6, 8'd1, 1, 4'd6, 2'b01, 20);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst("burst_stall", 4'd2, 8'd3, 3, 4'd2, 2'b00, 40);
    test_burst("early_last", 4'd3, 8'd2, 1, 4'd3, 2'b00, 25);
    test_burst("id_mismatch", 4'd3, 8'd0, 0, 4'd5, 2'b00, 10);
    test_burst("okay_resp", 4'd7, 8'd4, 4, 4'd7, 2'b01, 30);
    test_burst("len255", 4'd12, 8'd255, 255, 4'd12, 2'b00, 15);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
